// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular fetch buffer between fetch and dispatch
// Accepts up to WAYS in-order lanes per cycle and presents the oldest WAYS entries.
module fetch_buffer #(
    parameter int WAYS  = 3,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush_i,
    input  logic [WAYS-1:0]                  in_valid_i,
    input  logic [WAYS-1:0][XLEN-1:0]        in_pc_i,
    input  logic [WAYS-1:0][XLEN-1:0]        in_npc_i,
    input  logic [WAYS-1:0][XLEN-1:0]        in_inst_i,
    input  logic [$clog2(WAYS+1)-1:0]        dispatch_num_i,
    output logic [WAYS-1:0]                  out_valid_o,
    output logic [WAYS-1:0][XLEN-1:0]        out_pc_o,
    output logic [WAYS-1:0][XLEN-1:0]        out_npc_o,
    output logic [WAYS-1:0][XLEN-1:0]        out_inst_o,
    output logic                             stall_en_o,
    output logic [$clog2(WAYS)-1:0]          first_stall_idx_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(WAYS);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] npc_q  [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];

    logic [CW-1:0]   n_in;
    logic [CW-1:0]   free;
    logic [CW-1:0]   n_acc;
    logic [CW-1:0]   n_req;
    logic [CW-1:0]   n_deq;
    logic            run;

    // Only the unbroken run of valid lanes starting at lane 0 counts as the group.
    always_comb begin
        n_in = '0;
        run  = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (run && in_valid_i[i]) begin
                n_in = n_in + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Space comes from registered occupancy only; same-cycle dequeues do not free slots.
    always_comb begin
        free  = CW'(DEPTH) - count_q;
        n_acc = (n_in < free) ? n_in : free;
        n_req = CW'(dispatch_num_i);
        n_deq = (n_req < count_q) ? n_req : count_q;
    end

    always_comb begin
        stall_en_o        = (n_acc < n_in) && !flush_i && !reset;
        first_stall_idx_o = stall_en_o ? SW'(n_acc) : '0;
    end

    always_comb begin
        head_d  = head_q + PW'(n_deq);
        tail_d  = tail_q + PW'(n_acc);
        count_d = count_q + n_acc - n_deq;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                pc_q[e]   <= '0;
                npc_q[e]  <= '0;
                inst_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (!flush_i) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (CW'(i) < n_acc) begin
                        pc_q[tail_q + PW'(i)]   <= in_pc_i[i];
                        npc_q[tail_q + PW'(i)]  <= in_npc_i[i];
                        inst_q[tail_q + PW'(i)] <= in_inst_i[i];
                    end
                end
            end
        end
    end

    // Lane i shows the i-th oldest entry; empty lanes are forced to zero.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            out_valid_o[i] = (CW'(i) < count_q);
            out_pc_o[i]    = out_valid_o[i] ? pc_q[head_q + PW'(i)]   : '0;
            out_npc_o[i]   = out_valid_o[i] ? npc_q[head_q + PW'(i)]  : '0;
            out_inst_o[i]  = out_valid_o[i] ? inst_q[head_q + PW'(i)] : '0;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
module tb_fetch_buffer;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush_i;
    logic [2:0]        in_valid_i;
    logic [2:0][31:0]  in_pc_i;
    logic [2:0][31:0]  in_npc_i;
    logic [2:0][31:0]  in_inst_i;
    logic [1:0]        dispatch_num_i;
    logic [2:0]        out_valid_o;
    logic [2:0][31:0]  out_pc_o;
    logic [2:0][31:0]  out_npc_o;
    logic [2:0][31:0]  out_inst_o;
    logic              stall_en_o;
    logic [1:0]        first_stall_idx_o;
    logic [3:0]        count_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_buffer #(.WAYS(3), .DEPTH(8), .XLEN(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_pc_i           (in_pc_i),
        .in_npc_i          (in_npc_i),
        .in_inst_i         (in_inst_i),
        .dispatch_num_i    (dispatch_num_i),
        .out_valid_o       (out_valid_o),
        .out_pc_o          (out_pc_o),
        .out_npc_o         (out_npc_o),
        .out_inst_o        (out_inst_o),
        .stall_en_o        (stall_en_o),
        .first_stall_idx_o (first_stall_idx_o),
        .count_o           (count_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [1:0] d);
        in_valid_i     = v;
        in_pc_i[0]     = p0;
        in_pc_i[1]     = p1;
        in_pc_i[2]     = p2;
        for (int k = 0; k < 3; k++) begin
            in_npc_i[k]  = in_pc_i[k] + 32'd4;
            in_inst_i[k] = in_pc_i[k] ^ 32'hA5A5_0000;
        end
        dispatch_num_i = d;
        #1;
    endtask

    // Advance through a rising edge and settle at the following negative edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        flush_i = 1'b0;
        @(negedge clock);
        drive(3'b111, 32'h0, 32'h4, 32'h8, 2'd0);
        chk("stall_in_reset_empty", 32'(stall_en_o), 32'd0);
        tick();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_pc0", out_pc_o[0], 32'd0);
        chk("rst_out_inst2", out_inst_o[2], 32'd0);
        chk("rst_stall", 32'(stall_en_o), 32'd0);
        chk("rst_fsi", 32'(first_stall_idx_o), 32'd0);
        reset = 1'b0;

        // First group; nothing visible until the edge.
        drive(3'b111, 32'h0, 32'h4, 32'h8, 2'd0);
        chk("g1_stall", 32'(stall_en_o), 32'd0);
        chk("g1_no_bypass", 32'(out_valid_o), 32'd0);
        tick();
        chk("g1_count", 32'(count_o), 32'd3);
        chk("g1_valid", 32'(out_valid_o), 32'b111);
        chk("g1_pc0", out_pc_o[0], 32'h0);
        chk("g1_pc1", out_pc_o[1], 32'h4);
        chk("g1_pc2", out_pc_o[2], 32'h8);
        chk("g1_npc2", out_npc_o[2], 32'hC);
        chk("g1_inst1", out_inst_o[1], 32'hA5A5_0004);

        drive(3'b111, 32'hC, 32'h10, 32'h14, 2'd0);
        tick();
        chk("g2_count", 32'(count_o), 32'd6);
        drive(3'b001, 32'h18, 32'h0, 32'h0, 2'd0);
        tick();
        chk("g3_count", 32'(count_o), 32'd7);

        // One slot left for a three-lane group.
        drive(3'b111, 32'h1C, 32'h20, 32'h24, 2'd0);
        chk("c7_stall", 32'(stall_en_o), 32'd1);
        chk("c7_fsi", 32'(first_stall_idx_o), 32'd1);
        tick();
        chk("c7_count", 32'(count_o), 32'd8);

        drive(3'b111, 32'h20, 32'h24, 32'h28, 2'd0);
        chk("full_stall", 32'(stall_en_o), 32'd1);
        chk("full_fsi", 32'(first_stall_idx_o), 32'd0);
        tick();
        chk("full_count", 32'(count_o), 32'd8);

        // Dequeue does not free space in the same cycle.
        drive(3'b111, 32'h20, 32'h24, 32'h28, 2'd3);
        chk("fulldq_stall", 32'(stall_en_o), 32'd1);
        chk("fulldq_fsi", 32'(first_stall_idx_o), 32'd0);
        tick();
        chk("fulldq_count", 32'(count_o), 32'd5);
        chk("fulldq_pc0", out_pc_o[0], 32'hC);
        chk("fulldq_pc2", out_pc_o[2], 32'h14);

        drive(3'b111, 32'h60, 32'h64, 32'h68, 2'd2);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(stall_en_o), 32'd0);
        chk("flush_fsi", 32'(first_stall_idx_o), 32'd0);
        tick();
        flush_i = 1'b0;
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        chk("flush_pc0", out_pc_o[0], 32'd0);

        // Walk head and tail to 6 with an empty buffer.
        drive(3'b111, 32'h40, 32'h44, 32'h48, 2'd0);
        tick();
        drive(3'b111, 32'h4C, 32'h50, 32'h54, 2'd3);
        tick();
        chk("walk_count", 32'(count_o), 32'd3);
        chk("walk_pc0", out_pc_o[0], 32'h4C);
        drive(3'b000, 32'h0, 32'h0, 32'h0, 2'd3);
        tick();
        chk("empty_count", 32'(count_o), 32'd0);
        chk("empty_valid", 32'(out_valid_o), 32'd0);
        drive(3'b000, 32'h0, 32'h0, 32'h0, 2'd3);
        tick();
        chk("empty_dq_count", 32'(count_o), 32'd0);

        // Group straddles slots 6,7,0; dispatch on empty buffer is ignored.
        drive(3'b111, 32'h100, 32'h104, 32'h108, 2'd3);
        tick();
        chk("wrap_count", 32'(count_o), 32'd3);
        chk("wrap_pc0", out_pc_o[0], 32'h100);
        chk("wrap_pc1", out_pc_o[1], 32'h104);
        chk("wrap_pc2", out_pc_o[2], 32'h108);
        chk("wrap_npc2", out_npc_o[2], 32'h10C);

        drive(3'b000, 32'h0, 32'h0, 32'h0, 2'd1);
        tick();
        chk("c2_count", 32'(count_o), 32'd2);
        chk("c2_valid", 32'(out_valid_o), 32'b011);
        chk("c2_pc0", out_pc_o[0], 32'h104);
        chk("c2_pc2_zero", out_pc_o[2], 32'd0);

        // Lane 2 is ignored after the gap; dispatch 3 clamps to 2.
        drive(3'b101, 32'h200, 32'h204, 32'h208, 2'd3);
        chk("gap_stall", 32'(stall_en_o), 32'd0);
        tick();
        chk("gap_count", 32'(count_o), 32'd1);
        chk("gap_valid", 32'(out_valid_o), 32'b001);
        chk("gap_pc0", out_pc_o[0], 32'h200);

        drive(3'b010, 32'h300, 32'h304, 32'h308, 2'd0);
        tick();
        chk("lead0_count", 32'(count_o), 32'd1);

        drive(3'b111, 32'h400, 32'h404, 32'h408, 2'd0);
        tick();
        drive(3'b111, 32'h40C, 32'h410, 32'h414, 2'd0);
        tick();
        chk("refill_count", 32'(count_o), 32'd7);

        // Reset while full with valid input: no stall, clean state after.
        drive(3'b111, 32'h500, 32'h504, 32'h508, 2'd2);
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(stall_en_o), 32'd0);
        tick();
        reset = 1'b0;
        chk("rst_mid_count", 32'(count_o), 32'd0);
        chk("rst_mid_valid", 32'(out_valid_o), 32'd0);

        drive(3'b001, 32'h600, 32'h0, 32'h0, 2'd0);
        tick();
        chk("post_rst_count", 32'(count_o), 32'd1);
        chk("post_rst_pc0", out_pc_o[0], 32'h600);
        chk("post_rst_npc0", out_npc_o[0], 32'h604);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Fetch buffer sitting between the fetch stage and dispatch. It accepts up to `WAYS` in-order instructions per cycle from fetch, holds them in a circular FIFO, and presents the oldest `WAYS` entries to dispatch. When the FIFO cannot take a full fetch group, it returns the stall packet (`enable`, `first_stall_idx`) that fetch uses to redirect its PC. A branch flush empties the buffer.

## Interface
- `WAYS`, 3, superscalar width (lanes in and out)
- `DEPTH`, 8, FIFO entries; power of two, ≥ `WAYS`
- `XLEN`, 32, address/instruction width
- `clock` input 1 rising-edge clock
- `reset` input 1 synchronous, active-high
- `flush` input 1 branch flush; discard all held and incoming instructions
- `in_valid` input `WAYS` per-lane valid from fetch
- `in_pc`, `in_npc`, `in_inst` input `WAYS`×`XLEN` each; per-lane PC, PC+4, instruction
- `dispatch_num` input `$clog2(WAYS+1)`; entries dispatch consumes this cycle, taken from lane 0 upward
- `out_valid` output `WAYS`; lane i holds the i-th oldest entry
- `out_pc`, `out_npc`, `out_inst` output `WAYS`×`XLEN` each; contents for each lane
- `stall_en` output 1; fetch must restart from lane `first_stall_idx`
- `first_stall_idx` output `$clog2(WAYS)`; first lane not accepted
- `count` output `$clog2(DEPTH+1)`; current occupancy

## Operation
- State:
  - `head` and `tail` pointers, each `$clog2(DEPTH)` bits, wrap modulo `DEPTH`.
  - `count`, 0..`DEPTH`.
  - Entry array holding pc, npc and inst.
- Incoming group:
  - `n_in` = number of leading set bits of `in_valid`. Lanes after the first clear lane are ignored.
  - `free` = `DEPTH − count`, from registered `count`. Same-cycle dequeues do not add space.
  - `n_acc` = min(`n_in`, `free`).
  - Accepted lanes 0..`n_acc−1` are written at `tail`, `tail+1`, … with wrap.
- Stall:
  - `stall_en` = (`n_acc` < `n_in`) & ~`flush` & ~`reset`.
  - `first_stall_idx` = `n_acc` when `stall_en` is 1, else 0.
- Dequeue:
  - `n_deq` = min(`dispatch_num`, `count`). A request beyond `count` is clamped silently.
  - `head` advances by `n_deq`.
- Output lanes:
  - `out_valid[i]` = (i < `count`).
  - `out_*[i]` = entry[(`head`+i) mod `DEPTH`].
  - Lanes with `out_valid` = 0 drive 0.
- Next state: `count` ← `count` + `n_acc` − `n_deq`. Enqueue and dequeue occur in the same cycle independently.
- Flush takes priority over everything:
  - Next cycle: `head` = `tail` = `count` = 0.
  - No enqueue, no dequeue.
  - `stall_en` = 0 during the flush cycle.
- Reset gives the same next state as flush, with entry contents cleared to 0. During reset, `stall_en` = 0.

## Timing
- Enqueue to visibility: 1 cycle. An instruction accepted at edge N appears on `out_*` after edge N; there is no same-cycle bypass.
- `out_*`, `out_valid` and `count` are functions of registered state only.
- `stall_en` and `first_stall_idx` are combinational from `in_valid`, `count`, `flush` and `reset`. Fetch samples them at the same edge.
- Dequeue is effective at the edge; entries vacated at edge N are refillable from cycle N+1.
- Full (`count` = `DEPTH`):
  - `n_acc` = 0.
  - If `n_in` > 0, `stall_en` = 1 with `first_stall_idx` = 0.
- Empty: all `out_valid` are 0; `dispatch_num` is ignored.
- Wrap-around: a group straddling index `DEPTH−1`→0 is stored and read contiguously in program order.
- Flush and reset mid-operation: the state after the edge is identical to the post-reset state regardless of inputs.
- Reset values: `out_valid` = 0, all `out_*` = 0, `count` = 0, `stall_en` = 0, `first_stall_idx` = 0.

## Test plan
- Reset, then `in_valid` = 3'b111 with PCs 0x0/0x4/0x8 and `dispatch_num` = 0:
  - Next cycle: `count` = 3, `out_valid` = 3'b111, `out_pc` = {0x8,0x4,0x0}, `stall_en` = 0.
- Fill to `count` = 7, present 3 valid lanes:
  - `stall_en` = 1, `first_stall_idx` = 1.
  - Next cycle `count` = 8.
  - Retry with 3 lanes while full: `first_stall_idx` = 0 and `count` stays 8.
- `count` = 8, `dispatch_num` = 3 and 3 valid inputs in the same cycle:
  - `stall_en` = 1, `first_stall_idx` = 0.
  - Next cycle `count` = 5.
- Wrap: `head` = 6, `tail` = 6, enqueue PCs 0x100/0x104/0x108:
  - Entries land at 6, 7, 0.
  - Next cycle `out_pc` = {0x108,0x104,0x100}.
- `count` = 5, assert `flush` together with 3 valid inputs and `dispatch_num` = 2:
  - Next cycle `count` = 0, `out_valid` = 0, `stall_en` was 0.
- `count` = 2, `dispatch_num` = 3, `in_valid` = 3'b101:
  - Only lane 0 is enqueued; `n_deq` = 2.
  - Next cycle `count` = 1, holding lane 0's pc.
